// File: rtl/txn_arb_if.sv
// Bundle of the fabric-side request ports and the shared txn memory port.
// master is the arbiter's view; slave is the environment (requesters plus memory).
interface txn_arb_if #(
    parameter int NPORT = 4
);
    logic [NPORT-1:0]      m_req;
    logic [NPORT-1:0]      m_wr;
    logic [32*NPORT-1:0]   m_addr;
    logic [32*NPORT-1:0]   m_wdata;
    logic [NPORT-1:0]      m_done;
    logic                  m_err;
    logic [31:0]           m_rdata;
    logic                  txn_req;
    logic                  txn_wr;
    logic [31:0]           txn_addr;
    logic [31:0]           txn_wdata;
    logic [31:0]           txn_rdata;
    logic                  txn_rdy;
    logic [15:0]           txn_count;

    modport master (
        input  m_req, m_wr, m_addr, m_wdata, txn_rdata, txn_rdy,
        output m_done, m_err, m_rdata, txn_req, txn_wr, txn_addr, txn_wdata, txn_count
    );

    modport slave (
        output m_req, m_wr, m_addr, m_wdata, txn_rdata, txn_rdy,
        input  m_done, m_err, m_rdata, txn_req, txn_wr, txn_addr, txn_wdata, txn_count
    );
endinterface

// File: rtl/txn_arb.sv
// Round-robin arbiter sharing one txn memory port among NPORT requesters.
// Each grant runs req -> rdy low -> rdy high, with a bounded wait and a completion counter.
module txn_arb #(
    parameter int NPORT   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      srst,
    txn_arb_if.master bus
);
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] g;
    logic [IW-1:0] pick;
    logic [TW-1:0] tcnt;
    logic          expired;

    // First requesting port after the previous winner, wrapping modulo NPORT.
    function automatic logic [IW-1:0] rr_pick(input logic [NPORT-1:0] req, input logic [IW-1:0] from);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = from;
        found = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = (int'(from) + k) % NPORT;
            if (!found && req[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (int'(v) >= TIMEOUT) ? v : v + TW'(1);
    endfunction

    assign pick = rr_pick(bus.m_req, last);
    // The abort fires on the edge where the wait would reach TIMEOUT cycles.
    assign expired = (int'(tcnt) >= TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (srst) begin
            state          <= IDLE;
            last           <= IW'(NPORT - 1);
            g              <= '0;
            tcnt           <= '0;
            bus.m_done     <= '0;
            bus.m_err      <= 1'b0;
            bus.m_rdata    <= '0;
            bus.txn_req    <= 1'b0;
            bus.txn_wr     <= 1'b0;
            bus.txn_addr   <= '0;
            bus.txn_wdata  <= '0;
            bus.txn_count  <= '0;
        end else begin
            bus.m_done <= '0;
            bus.m_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Memory must be ready before a new issue, even after a reset mid-operation.
                    if (bus.txn_rdy && (bus.m_req != '0)) begin
                        g             <= pick;
                        last          <= pick;
                        bus.txn_wr    <= bus.m_wr[pick];
                        bus.txn_addr  <= bus.m_addr[32*int'(pick) +: 32];
                        bus.txn_wdata <= bus.m_wdata[32*int'(pick) +: 32];
                        bus.txn_req   <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.txn_req <= 1'b0;
                    tcnt        <= '0;
                    state       <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!bus.txn_rdy) begin
                        tcnt  <= '0;
                        state <= WAIT_HI;
                    end else if (expired) begin
                        bus.m_done[g] <= 1'b1;
                        bus.m_err     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tcnt <= sat_inc(tcnt);
                    end
                end
                WAIT_HI: begin
                    if (bus.txn_rdy) begin
                        bus.m_rdata   <= bus.txn_rdata;
                        bus.txn_count <= bus.txn_count + 16'd1;
                        bus.m_done[g] <= 1'b1;
                        state         <= RESP;
                    end else if (expired) begin
                        bus.m_done[g] <= 1'b1;
                        bus.m_err     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tcnt <= sat_inc(tcnt);
                    end
                end
                RESP: begin
                    // One edge for the requester to drop m_req before IDLE samples again.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_txn_arb.sv
// Bench for txn_arb: directed scenarios plus randomized traffic against a
// transaction-level model of grant order, memory contents and completion count.
module tb_txn_arb;
    localparam int NP  = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    txn_arb_if #(.NPORT(NP)) bus();

    txn_arb #(.NPORT(NP), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    // Memory stub: accepts a one-cycle req, drops rdy, raises it after a latency.
    logic [31:0] mem [16];
    logic [31:0] mem_init [16];
    logic        mem_load  = 1'b0;
    logic        mem_rdy   = 1'b1;
    logic        mem_busy  = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_wr_l  = 1'b0;
    logic [3:0]  mem_idx_l = '0;
    logic [31:0] mem_wd_l  = '0;
    int          mem_cnt   = 0;
    logic        hang      = 1'b0;
    logic        block_rdy = 1'b0;
    int          lat_lo    = 0;
    int          lat_hi    = 0;

    assign bus.txn_rdy   = mem_rdy & ~block_rdy;
    assign bus.txn_rdata = mem_rdata;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= mem_init[i];
        end else if (!mem_busy) begin
            if (bus.txn_req === 1'b1) begin
                mem_busy  <= 1'b1;
                mem_rdy   <= 1'b0;
                mem_wr_l  <= bus.txn_wr;
                mem_idx_l <= bus.txn_addr[5:2];
                mem_wd_l  <= bus.txn_wdata;
                mem_cnt   <= int'($urandom_range(lat_hi, lat_lo));
            end
        end else if (!hang) begin
            if (mem_cnt == 0) begin
                mem_busy <= 1'b0;
                mem_rdy  <= 1'b1;
                if (mem_wr_l) mem[mem_idx_l] <= mem_wd_l;
                else          mem_rdata      <= mem[mem_idx_l];
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [16];
    int          last_m;
    int          exp_count;
    logic [31:0] exp_rdata;
    int          left    [NP];
    logic        p_wr    [NP];
    logic [31:0] p_addr  [NP];
    logic [31:0] p_wdata [NP];
    int          gap_cnt [NP];
    int          order_q [$];

    // Round robin: the winner is the pending port closest after the last winner.
    function automatic int model_grant(input logic [NP-1:0] pend, input int from);
        int j;
        for (int k = 1; k <= NP; k++) begin
            j = (from + k) % NP;
            if (pend[j[1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic int any_left();
        int s;
        s = 0;
        for (int p = 0; p < NP; p++) s += left[p];
        return s;
    endfunction

    task automatic drive_port(input int p);
        bus.m_wr[p]              = p_wr[p];
        bus.m_addr[32*p +: 32]   = p_addr[p];
        bus.m_wdata[32*p +: 32]  = p_wdata[p];
    endtask

    task automatic new_txn(input int p);
        logic [3:0] idx;
        idx        = 4'($urandom_range(0, 15));
        p_wr[p]    = 1'($urandom_range(0, 1));
        p_addr[p]  = 32'h4000_0000 | {26'd0, idx, 2'b00};
        p_wdata[p] = $urandom;
        drive_port(p);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        srst      = 1'b0;
        last_m    = NP - 1;
        exp_count = 0;
        exp_rdata = '0;
    endtask

    task automatic run_traffic(input int max_gap, input int budget);
        int          cur;
        int          w;
        int          cyc;
        logic        busy_m;
        logic [NP-1:0] pend;
        busy_m = 1'b0;
        cur    = 0;
        cyc    = 0;
        for (int p = 0; p < NP; p++) begin
            gap_cnt[p] = 0;
            if (left[p] > 0) begin
                drive_port(p);
                bus.m_req[p] = 1'b1;
            end else begin
                bus.m_req[p] = 1'b0;
            end
        end
        while (cyc < budget && (busy_m || any_left() > 0)) begin
            @(negedge clk);
            cyc++;
            pend = bus.m_req;
            if (bus.txn_req === 1'b1) begin
                check("txn_req_single", 32'(busy_m), 32'd0);
                w = model_grant(pend, last_m);
                check("txn_req_has_requester", 32'(w < 0), 32'd0);
                if (w >= 0) begin
                    check("txn_addr", bus.txn_addr, p_addr[w]);
                    check("txn_wr", 32'(bus.txn_wr), 32'(p_wr[w]));
                    check("txn_wdata", bus.txn_wdata, p_wdata[w]);
                    cur    = w;
                    last_m = w;
                    busy_m = 1'b1;
                    order_q.push_back(w);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (gap_cnt[p] > 0) begin
                    gap_cnt[p]--;
                    if (gap_cnt[p] == 0) begin
                        new_txn(p);
                        bus.m_req[p] = 1'b1;
                    end
                end
            end
            if (bus.m_done !== '0) begin
                check("m_done_in_flight", 32'(busy_m), 32'd1);
                check("m_done_onehot", 32'(bus.m_done), 32'd1 << cur);
                check("m_err", 32'(bus.m_err), 32'd0);
                if (!p_wr[cur]) begin
                    exp_rdata = ref_mem[p_addr[cur][5:2]];
                    check("m_rdata", bus.m_rdata, exp_rdata);
                end else begin
                    ref_mem[p_addr[cur][5:2]] = p_wdata[cur];
                end
                exp_count++;
                check("txn_count", 32'(bus.txn_count), exp_count & 32'hFFFF);
                busy_m         = 1'b0;
                left[cur]--;
                bus.m_req[cur] = 1'b0;
                if (left[cur] > 0) gap_cnt[cur] = int'($urandom_range(0, max_gap)) + 1;
            end
        end
        check("traffic_within_budget", 32'(busy_m || any_left() > 0), 32'd0);
    endtask

    initial begin
        int   exp_rr [5];
        int   exp_bb [3];
        int   n;
        logic seen;

        srst         = 1'b1;
        bus.m_req    = '0;
        bus.m_wr     = '0;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        for (int i = 0; i < 16; i++) mem_init[i] = $urandom;
        mem_init[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_init[i];
        for (int p = 0; p < NP; p++) begin
            left[p] = 0; p_wr[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; gap_cnt[p] = 0;
        end
        mem_load = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;
        do_reset();

        // Reset state
        check("rst_m_done", 32'(bus.m_done), 32'd0);
        check("rst_m_err", 32'(bus.m_err), 32'd0);
        check("rst_m_rdata", bus.m_rdata, 32'd0);
        check("rst_txn_req", 32'(bus.txn_req), 32'd0);
        check("rst_txn_wr", 32'(bus.txn_wr), 32'd0);
        check("rst_txn_addr", bus.txn_addr, 32'd0);
        check("rst_txn_wdata", bus.txn_wdata, 32'd0);
        check("rst_txn_count", 32'(bus.txn_count), 32'd0);

        // Single read from port 1
        left[1] = 1; p_wr[1] = 1'b0; p_addr[1] = 32'h4000_0004; p_wdata[1] = '0;
        run_traffic(0, 50);
        check("read_rdata", bus.m_rdata, 32'hDEAD_BEEF);
        check("read_count", 32'(bus.txn_count), 32'd1);

        // Single write from port 2
        left[2] = 1; p_wr[2] = 1'b1; p_addr[2] = 32'h4000_2008; p_wdata[2] = 32'h1234_5678;
        run_traffic(0, 50);
        check("write_mem_word2", mem[2], 32'h1234_5678);

        // Round robin with all ports requesting from reset
        do_reset();
        exp_rr = '{0, 1, 2, 3, 0};
        for (int p = 0; p < NP; p++) begin
            new_txn(p);
            left[p] = 1;
        end
        left[0] = 2;
        lat_lo = 0; lat_hi = 2;
        order_q.delete();
        run_traffic(0, 200);
        check("rr_grants", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < order_q.size(); i++) check("rr_order", 32'(order_q[i]), 32'(exp_rr[i]));

        // Back-to-back: port 0 re-requests while port 3 waits
        do_reset();
        exp_bb = '{0, 3, 0};
        new_txn(0); new_txn(3);
        left[0] = 2; left[3] = 1;
        order_q.delete();
        run_traffic(0, 200);
        check("b2b_grants", 32'(order_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < order_q.size(); i++) check("b2b_order", 32'(order_q[i]), 32'(exp_bb[i]));

        // No issue while txn_rdy is low
        @(negedge clk);
        block_rdy = 1'b1;
        new_txn(1);
        bus.m_req[1] = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.txn_req === 1'b1) seen = 1'b1;
        end
        check("no_issue_rdy_low", 32'(seen), 32'd0);
        block_rdy = 1'b0;
        left[1] = 1;
        run_traffic(0, 50);

        // Reset during WAIT_HI
        lat_lo = 8; lat_hi = 8;
        repeat (2) @(negedge clk);
        new_txn(2);
        p_wr[2] = 1'b0;
        drive_port(2);
        bus.m_req[2] = 1'b1;
        n = 0;
        while (bus.txn_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rstop_issue_seen", 32'(bus.txn_req), 32'd1);
        repeat (2) @(negedge clk);
        check("rstop_rdy_low", 32'(bus.txn_rdy), 32'd0);
        srst = 1'b1;
        @(negedge clk);
        check("rstop_txn_req", 32'(bus.txn_req), 32'd0);
        check("rstop_m_done", 32'(bus.m_done), 32'd0);
        check("rstop_txn_count", 32'(bus.txn_count), 32'd0);
        srst      = 1'b0;
        last_m    = NP - 1;
        exp_count = 0;
        exp_rdata = '0;
        seen = 1'b0;
        n = 0;
        while (bus.txn_rdy !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.txn_req === 1'b1) seen = 1'b1;
        end
        check("rstop_no_issue_busy", 32'(seen), 32'd0);
        check("rstop_rdy_back", 32'(bus.txn_rdy), 32'd1);
        lat_lo = 0; lat_hi = 3;
        left[2] = 1;
        run_traffic(0, 50);

        // Timeout with a memory that never completes
        hang = 1'b1;
        @(negedge clk);
        new_txn(1);
        p_wr[1] = 1'b0;
        drive_port(1);
        bus.m_req[1] = 1'b1;
        n = 0;
        while (bus.txn_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("tmo_issue_seen", 32'(bus.txn_req), 32'd1);
        last_m = 1;
        n = 0;
        while (bus.m_done === '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", 32'(n), 32'd17);
        check("tmo_m_done", 32'(bus.m_done), 32'b0010);
        check("tmo_m_err", 32'(bus.m_err), 32'd1);
        check("tmo_m_rdata_held", bus.m_rdata, exp_rdata);
        check("tmo_count_held", 32'(bus.txn_count), exp_count & 32'hFFFF);
        bus.m_req[1] = 1'b0;
        @(negedge clk);
        check("tmo_done_cleared", 32'(bus.m_done), 32'd0);
        check("tmo_err_cleared", 32'(bus.m_err), 32'd0);
        new_txn(1);
        bus.m_req[1] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.txn_req === 1'b1) seen = 1'b1;
        end
        check("tmo_no_issue_hung", 32'(seen), 32'd0);
        hang = 1'b0;
        left[1] = 1;
        run_traffic(0, 60);

        // Randomized traffic
        lat_lo = 0; lat_hi = 4;
        for (int p = 0; p < NP; p++) begin
            new_txn(p);
            left[p] = int'($urandom_range(3, 6));
        end
        run_traffic(3, 3000);
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
